// File: rtl/eth_frame_tx.sv
// Ethernet frame generator for a TEMAC AXI4-Stream TX port: header, sequence/timestamp, payload, gap.
// Define ETH_FRAME_TX_LFSR_EN for LFSR payload and time_running-gated frame starts.
module eth_frame_tx #(
  parameter int C_MIN_SIZE = 60,
  parameter int C_MAX_SIZE = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] frame_size,
  input  logic [15:0] idle_cycles,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [63:0] current_time,
  input  logic        time_running,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        frame_sent,
  output logic [63:0] tx_frames,
  output logic [63:0] tx_bytes
);

  typedef enum logic [2:0] {IDLE, HEADER, STAMP, PAYLOAD, GAP} state_t;

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d, size_q, size_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [15:0] etype_q, etype_d, gap_q, gap_d;
  logic [63:0] ts_q, ts_d, frames_q, frames_d, bytes_q, bytes_d;
  logic [31:0] seq_q, seq_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, sent_q, sent_d;
  logic        start_ok, beat, restart;
  logic [10:0] nidx, clamped;
  logic [111:0] hdr;
  logic [95:0]  stamp;
  logic [3:0]   hdr_sel, stamp_sel;

`ifdef ETH_FRAME_TX_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  assign start_ok = enable && time_running;
`else
  logic unused_time_running;
  assign unused_time_running = time_running;
  assign start_ok = enable;
`endif

  assign beat      = tvalid_q && m_axis_tready;
  assign nidx      = idx_q + 11'd1;
  assign clamped   = (frame_size < 11'(C_MIN_SIZE)) ? 11'(C_MIN_SIZE) :
                     (frame_size > 11'(C_MAX_SIZE)) ? 11'(C_MAX_SIZE) : frame_size;
  assign hdr       = {dst_q, src_q, etype_q};
  assign stamp     = {seq_q, ts_q};
  assign hdr_sel   = (nidx < 11'd14) ? 4'(11'd13 - nidx) : 4'd0;
  assign stamp_sel = (nidx >= 11'd14 && nidx < 11'd26) ? 4'(11'd25 - nidx) : 4'd0;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    size_d   = size_q;
    dst_d    = dst_q;
    src_d    = src_q;
    etype_d  = etype_q;
    gap_d    = gap_q;
    ts_d     = ts_q;
    frames_d = frames_q;
    bytes_d  = bytes_q;
    seq_d    = seq_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    sent_d   = 1'b0;
    restart  = 1'b0;
`ifdef ETH_FRAME_TX_LFSR_EN
    lfsr_d   = lfsr_q;
`endif
    case (state_q)
      IDLE: restart = 1'b1;
      HEADER, STAMP, PAYLOAD: begin
        if (beat) begin
          if (idx_q == 11'd0) ts_d = current_time;
          if (tlast_q) begin
            frames_d = frames_q + 64'd1;
            bytes_d  = bytes_q + {53'd0, size_q};
            seq_d    = seq_q + 32'd1;
            sent_d   = 1'b1;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (idle_cycles != 16'd0) begin
              state_d = GAP;
              gap_d   = idle_cycles;
            end else begin
              restart = 1'b1;
            end
          end else begin
            idx_d   = nidx;
            tlast_d = (nidx == size_q - 11'd1);
            if (nidx < 11'd14) begin
              tdata_d = hdr[{hdr_sel, 3'b000} +: 8];
            end else if (nidx < 11'd26) begin
              state_d = STAMP;
              tdata_d = stamp[{stamp_sel, 3'b000} +: 8];
            end else begin
              state_d = PAYLOAD;
`ifdef ETH_FRAME_TX_LFSR_EN
              if (nidx == 11'd26) begin
                tdata_d = lfsr_q;
              end else begin
                lfsr_d  = lfsr_step(lfsr_q);
                tdata_d = lfsr_step(lfsr_q);
              end
`else
              tdata_d = 8'(nidx - 11'd26) + seq_q[7:0];
`endif
            end
          end
        end
      end
      GAP: begin
        if (gap_q <= 16'd1) restart = 1'b1;
        else gap_d = gap_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // Shared start decision: from IDLE, end of gap, or a zero-gap tlast for back-to-back frames
    if (restart) begin
      if (start_ok) begin
        state_d  = HEADER;
        idx_d    = 11'd0;
        size_d   = clamped;
        dst_d    = dst_mac;
        src_d    = src_mac;
        etype_d  = ethertype;
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        tdata_d  = dst_mac[47:40];
`ifdef ETH_FRAME_TX_LFSR_EN
        lfsr_d   = seq_d[7:0] | 8'h01;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      size_q   <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      etype_q  <= '0;
      gap_q    <= '0;
      ts_q     <= '0;
      frames_q <= '0;
      bytes_q  <= '0;
      seq_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      sent_q   <= 1'b0;
`ifdef ETH_FRAME_TX_LFSR_EN
      lfsr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      size_q   <= size_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      etype_q  <= etype_d;
      gap_q    <= gap_d;
      ts_q     <= ts_d;
      frames_q <= frames_d;
      bytes_q  <= bytes_d;
      seq_q    <= seq_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      sent_q   <= sent_d;
`ifdef ETH_FRAME_TX_LFSR_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = 1'b0;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != IDLE);
  assign frame_sent    = sent_q;
  assign tx_frames     = frames_q;
  assign tx_bytes      = bytes_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx: a frame-level reference model scores every accepted beat,
// stall stability, gaps and counters; a vector table plus hand sequences cover the corner cases.
module tb_eth_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] frame_size = 11'd64;
  logic [15:0] idle_cycles = 16'd0;
  logic [47:0] dst_mac = 48'h0102_0304_0506;
  logic [47:0] src_mac = 48'hA1A2_A3A4_A5A6;
  logic [15:0] ethertype = 16'h88B5;
  logic [63:0] current_time = 64'd0;
  logic        time_running = 1'b1;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        busy, frame_sent;
  logic [63:0] tx_frames, tx_bytes;

  always #5 clk = ~clk;

  eth_frame_tx dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_size(frame_size),
    .idle_cycles(idle_cycles), .dst_mac(dst_mac), .src_mac(src_mac),
    .ethertype(ethertype), .current_time(current_time), .time_running(time_running),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .busy(busy),
    .frame_sent(frame_sent), .tx_frames(tx_frames), .tx_bytes(tx_bytes)
  );

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [63:0] exp_frames = 64'd0, exp_bytes = 64'd0;
  logic [31:0] exp_seq = 32'd0;
  logic        rand_ready = 1'b0, check_gap = 1'b0;
  logic        in_frame = 1'b0, pend_sent = 1'b0, prev_stall = 1'b0, gap_armed = 1'b0;
  int          bidx = 0, gap_cnt = 0, exp_gap = 0, last_len = 0, fr_size = 0, gap_checks = 0;
  logic [47:0] fr_dst, fr_src;
  logic [15:0] fr_etype;
  logic [31:0] fr_seq;
  logic [63:0] fr_ts;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [7:0]  last_frame [0:1513];

  typedef struct {
    logic [10:0] size;
    logic [15:0] idle;
    logic        rnd;
    int          beats;
  } vec_t;
  vec_t vecs [10];

  function automatic int clamp_size(input int s);
    if (s < 60) return 60;
    if (s > 1514) return 1514;
    return s;
  endfunction

  // Expected byte i of the frame, built from the frame's field layout
  function automatic logic [7:0] exp_byte(input int i);
    logic [111:0] hdr;
    logic [95:0]  stamp;
    hdr   = {fr_dst, fr_src, fr_etype};
    stamp = {fr_seq, fr_ts};
    if (i < 14) return hdr[111-8*i -: 8];
    if (i < 26) return stamp[95-8*(i-14) -: 8];
    return 8'((i - 26) + int'(fr_seq[7:0]));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for one cycle, sampled at the falling edge
  task automatic observe();
    checkOutput("frame_sent", 64'(frame_sent), 64'(pend_sent));
    if (pend_sent) begin
      checkOutput("tx_frames", tx_frames, exp_frames);
      checkOutput("tx_bytes", tx_bytes, exp_bytes);
    end
    pend_sent = 1'b0;
    if (prev_stall) begin
      checkOutput("hold_valid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("hold_data", 64'(m_axis_tdata), 64'(prev_data));
      checkOutput("hold_last", 64'(m_axis_tlast), 64'(prev_last));
    end
    if (in_frame) checkOutput("valid_in_frame", 64'(m_axis_tvalid), 64'd1);
    if (m_axis_tvalid) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        bidx     = 0;
        fr_dst   = dst_mac;
        fr_src   = src_mac;
        fr_etype = ethertype;
        fr_size  = clamp_size(int'(frame_size));
        fr_seq   = exp_seq;
        if (gap_armed) begin
          checkOutput("gap_len", 64'(gap_cnt), 64'(exp_gap));
          gap_checks++;
          gap_armed = 1'b0;
        end
      end
      if (m_axis_tready) begin
        if (bidx == 0) fr_ts = current_time;
        checkOutput($sformatf("tdata[%0d]", bidx), 64'(m_axis_tdata), 64'(exp_byte(bidx)));
        checkOutput($sformatf("tlast[%0d]", bidx), 64'(m_axis_tlast), 64'(bidx == fr_size - 1));
        checkOutput("tuser", 64'(m_axis_tuser), 64'd0);
        if (bidx < 1514) last_frame[bidx] = m_axis_tdata;
        if (bidx == fr_size - 1) begin
          in_frame   = 1'b0;
          last_len   = fr_size;
          exp_frames = exp_frames + 64'd1;
          exp_bytes  = exp_bytes + 64'(fr_size);
          exp_seq    = exp_seq + 32'd1;
          pend_sent  = 1'b1;
          gap_cnt    = 0;
          gap_armed  = check_gap;
          exp_gap    = int'(idle_cycles);
        end else begin
          bidx++;
        end
      end
    end else if (!in_frame) begin
      gap_cnt++;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
  endtask

  // One clock: drive ready and timer at the falling edge, then score
  task automatic applyStimulus();
    @(negedge clk);
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    current_time  = {$urandom, $urandom};
    observe();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_frames", tx_frames, 64'd0);
    checkOutput("rst_bytes", tx_bytes, 64'd0);
    in_frame = 1'b0; bidx = 0; pend_sent = 1'b0; prev_stall = 1'b0; gap_armed = 1'b0;
    exp_frames = 64'd0; exp_bytes = 64'd0; exp_seq = 32'd0; gap_cnt = 0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while ((busy || m_axis_tvalid || in_frame) && n < budget);
    checkOutput("idle_reached", {61'd0, in_frame, busy, m_axis_tvalid}, 64'd0);
    gap_armed = 1'b0;
  endtask

  task automatic waitFrames(input logic [63:0] target, input int budget);
    int n = 0;
    while (exp_frames < target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("frames_reached", 64'(exp_frames >= target), 64'd1);
  endtask

  task automatic waitBeat(input int k, input int budget);
    int n = 0;
    while (!(in_frame && bidx >= k) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("beat_reached", 64'(in_frame && bidx >= k), 64'd1);
  endtask

  task automatic startFrame();
    int lat = 0;
    do begin
      applyStimulus();
      lat++;
    end while (!in_frame && lat < 10);
    checkOutput("start_latency", 64'(lat), 64'd1);
  endtask

  initial begin
    logic [63:0] b0, f0;
    int          g0, quiet, rs;
    vecs[0] = '{size: 11'd20,   idle: 16'd0, rnd: 1'b0, beats: 60};
    vecs[1] = '{size: 11'd2000, idle: 16'd0, rnd: 1'b0, beats: 1514};
    vecs[2] = '{size: 11'd64,   idle: 16'd2, rnd: 1'b1, beats: 64};
    vecs[3] = '{size: 11'd59,   idle: 16'd0, rnd: 1'b1, beats: 60};
    vecs[4] = '{size: 11'd60,   idle: 16'd1, rnd: 1'b1, beats: 60};
    vecs[5] = '{size: 11'd61,   idle: 16'd0, rnd: 1'b0, beats: 61};
    vecs[6] = '{size: 11'd1514, idle: 16'd3, rnd: 1'b1, beats: 1514};
    vecs[7] = '{size: 11'd1515, idle: 16'd0, rnd: 1'b1, beats: 1514};
    vecs[8] = '{size: 11'd2047, idle: 16'd0, rnd: 1'b0, beats: 1514};
    vecs[9] = '{size: 11'd100,  idle: 16'd7, rnd: 1'b1, beats: 100};

    doReset();

    // Back-to-back 64-byte frames with continuous ready
    frame_size = 11'd64; idle_cycles = 16'd0; rand_ready = 1'b0; check_gap = 1'b1;
    enable = 1'b1;
    startFrame();
    waitFrames(64'd1, 200);
    checkOutput("t1_len", 64'(last_len), 64'd64);
    checkOutput("t1_seq0", 64'({last_frame[14], last_frame[15], last_frame[16], last_frame[17]}), 64'd0);
    checkOutput("t1_b0", 64'(last_frame[0]), 64'h01);
    checkOutput("t1_b13", 64'(last_frame[13]), 64'hB5);
    checkOutput("t1_b26", 64'(last_frame[26]), 64'h00);
    checkOutput("t1_b63", 64'(last_frame[63]), 64'h25);
    waitFrames(64'd2, 200);
    enable = 1'b0;
    check_gap = 1'b0;
    checkOutput("t1_seq1", 64'({last_frame[14], last_frame[15], last_frame[16], last_frame[17]}), 64'd1);
    checkOutput("t1_gaps", 64'(gap_checks), 64'd1);
    waitIdle(100);

    // Table: size clamping, ready stalls and gaps
    for (int i = 0; i < 10; i++) begin
      frame_size = vecs[i].size; idle_cycles = vecs[i].idle; rand_ready = vecs[i].rnd;
      dst_mac = {16'($urandom), $urandom}; src_mac = {16'($urandom), $urandom};
      ethertype = 16'($urandom);
      b0 = exp_bytes; f0 = exp_frames;
      enable = 1'b1;
      startFrame();
      enable = 1'b0;
      waitIdle(4000);
      checkOutput($sformatf("vec%0d_len", i), 64'(last_len), 64'(vecs[i].beats));
      checkOutput($sformatf("vec%0d_bytes", i), tx_bytes, b0 + 64'(vecs[i].beats));
      checkOutput($sformatf("vec%0d_frames", i), tx_frames, f0 + 64'd1);
    end

    // Random sizes, gaps and ready patterns
    for (int i = 0; i < 6; i++) begin
      rs = int'($urandom_range(0, 2047));
      frame_size = 11'(rs); idle_cycles = 16'($urandom_range(0, 4)); rand_ready = 1'b1;
      dst_mac = {16'($urandom), $urandom}; ethertype = 16'($urandom);
      b0 = exp_bytes;
      enable = 1'b1;
      startFrame();
      enable = 1'b0;
      waitIdle(4000);
      checkOutput($sformatf("rnd%0d_len", i), 64'(last_len), 64'(clamp_size(rs)));
      checkOutput($sformatf("rnd%0d_bytes", i), tx_bytes, b0 + 64'(clamp_size(rs)));
    end

    // Twelve-cycle gap between two frames
    frame_size = 11'd60; idle_cycles = 16'd12; rand_ready = 1'b1; check_gap = 1'b1;
    f0 = exp_frames; g0 = gap_checks;
    enable = 1'b1;
    waitFrames(f0 + 64'd2, 800);
    enable = 1'b0;
    check_gap = 1'b0;
    checkOutput("t4_gap_seen", 64'(gap_checks - g0), 64'd1);
    waitIdle(300);

    // Reset in the middle of a frame, restart with seq 0
    doReset();
    frame_size = 11'd100; idle_cycles = 16'd0; rand_ready = 1'b0;
    enable = 1'b1;
    waitBeat(40, 100);
    doReset();
    startFrame();
    enable = 1'b0;
    waitIdle(300);
    checkOutput("t6_seq0", 64'({last_frame[14], last_frame[15], last_frame[16], last_frame[17]}), 64'd0);
    checkOutput("t6_frames", tx_frames, 64'd1);

    // enable dropped at byte 30 of a 100-byte frame
    doReset();
    frame_size = 11'd100; idle_cycles = 16'd5; rand_ready = 1'b1;
    enable = 1'b1;
    waitBeat(30, 200);
    enable = 1'b0;
    waitIdle(500);
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      if (m_axis_tvalid) quiet++;
    end
    checkOutput("t5_quiet", 64'(quiet), 64'd0);
    checkOutput("t5_len", 64'(last_len), 64'd100);
    checkOutput("t5_frames", tx_frames, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_frame_tx.md
Name: eth_frame_tx

Overview:
- Ethernet frame generator driving the AXI4-Stream TX port of a TEMAC.
- Complements the frame detector path, which only receives and forwards.
- Builds each frame from register-supplied header fields, then inserts a sequence number and a timestamp from the shared timer, then a generated payload.
- Inserts a programmable inter-frame gap and keeps frame/byte counters for the AXI register block.

Parameters:
C_MIN_SIZE, 60, minimum frame length in bytes, excluding FCS (TEMAC appends FCS)
C_MAX_SIZE, 1514, maximum frame length in bytes, excluding FCS

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = generate frames continuously
frame_size  in  11  requested frame length in bytes
idle_cycles  in  16  gap in clk cycles after tlast is accepted
dst_mac  in  48  destination MAC, sent MSB byte first
src_mac  in  48  source MAC, sent MSB byte first
ethertype  in  16  EtherType, sent MSB byte first
current_time  in  64  shared timer value
time_running  in  1  timer active flag
m_axis_tdata  out  8  frame byte
m_axis_tuser  out  1  always 0 (no underrun abort)
m_axis_tlast  out  1  last byte of frame
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  TEMAC ready
busy  out  1  1 while in HEADER, STAMP, PAYLOAD or GAP
frame_sent  out  1  one-cycle pulse when the tlast beat is accepted
tx_frames  out  64  frames sent since reset
tx_bytes  out  64  bytes sent since reset

Behaviour:
- Reset values: tvalid=0, tlast=0, tuser=0, tdata=0, busy=0, frame_sent=0, tx_frames=0, tx_bytes=0, seq=0, state=IDLE. Reset mid-frame aborts at once with no tlast.
- Handshake:
  - A beat transfers when tvalid && tready.
  - While tvalid=1 && tready=0, tdata and tlast are held stable.
  - tvalid never drops mid-frame.
- Byte index: 11-bit counter idx, starting at 0 at frame start.
- States:
  - IDLE: if enable=1 (and, with the optional feature, time_running=1):
    - latch size = clamp(frame_size, C_MIN_SIZE, C_MAX_SIZE) and the header fields;
    - go to HEADER; tvalid=1 on the next cycle (1-cycle start latency).
  - HEADER: idx 0..13 = dst_mac[47:40]..dst_mac[7:0], src_mac bytes, ethertype[15:8], ethertype[7:0].
    - current_time is latched into ts on the cycle the idx 0 beat transfers.
  - STAMP: idx 14..17 = seq[31:24]..seq[7:0]; idx 18..25 = ts[63:56]..ts[7:0].
  - PAYLOAD: idx 26..size-1. Byte value = (idx - 26 + seq[7:0]) mod 256.
  - tlast=1 on idx = size-1. When that beat transfers:
    - tx_frames += 1, tx_bytes += size, seq += 1 (wraps at 2^32), frame_sent pulses;
    - go to GAP if idle_cycles != 0, else straight to IDLE evaluation.
    - Back-to-back case: the next frame's tvalid may assert on the cycle after tlast is accepted.
  - GAP: down-counter loaded with idle_cycles (latched when tlast is accepted); tvalid=0. Go to IDLE when the count reaches 0.
- enable deasserted mid-frame or in GAP: the current frame completes normally, the gap elapses, then the block stays in IDLE.
- Header and size changes mid-frame are ignored; they take effect at the next frame start.
- Counters wrap silently at 2^64.

Optional Feature:
- Macro: ETH_FRAME_TX_LFSR_EN.
- Defined:
  - payload bytes come from an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1;
  - the LFSR is seeded with seq[7:0]|1 at frame start and advances once per accepted payload beat;
  - frame start in IDLE additionally requires time_running=1.
- Undefined: incrementing payload as described above; time_running is ignored.

Test Plan:
1. Reset, enable=1, frame_size=64, idle_cycles=0, tready=1 -> 64 beats:
   - bytes 0-13 are the header; bytes 14-17 = 00 00 00 00; bytes 18-25 = current_time captured at beat 0;
   - byte 26 = 0x00, byte 63 = 0x25; tlast on beat 63;
   - the next frame's byte 14-17 carries seq = 1.
2. frame_size=20 and frame_size=2000 -> 60 and 1514 beats respectively; tx_bytes increments by 60, then 1514.
3. Random tready (~50% duty) -> tdata/tlast stable while stalled; the byte sequence is identical to the tready=1 run.
4. idle_cycles=12 -> exactly 12 cycles with tvalid=0 between tlast acceptance and the next idx 0 tvalid; frame_sent is a single-cycle pulse.
5. enable dropped at byte 30 of a 100-byte frame -> frame finishes with tlast on byte 99, then tvalid stays 0; tx_frames=1.
6. Assert rst at byte 40 -> tvalid=0 and all counters 0 immediately; after release with enable=1, the frame restarts at byte 0 with seq=0.
